clkgen_multi_div: RTL and testbench

- Parametrised multi-channel clock generator that derives NUM_CLOCKS divided clocks from refclk. Each clock has an independent integer divisor that can be reprogrammed at run time.
- Successor to the single fixed-ratio 5 MHz generator. Adds runtime divisor reconfiguration, glitch-free handover, a phase-alignment request, per-channel rising-edge strobes and lock reporting.
- Sits between the board oscillator (50 MHz) and the riser's slow bus/codec timing logic.

---
 rtl/clkgen_multi_div.sv | 132 +++++++++++++
 tb/tb_clkgen_multi_div.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_multi_div.sv
// Multi-channel integer clock divider: runtime divisor updates land on period boundaries,
// a global sync request realigns all channels, and locked reports stable ratios.
module clkgen_multi_div #(
    parameter int unsigned NUM_CLOCKS   = 2,
    parameter int unsigned DIV_WIDTH    = 8,
    parameter int unsigned DIV_DEFAULT0 = 10,
    parameter int unsigned DIV_DEFAULT1 = 25,
    parameter int unsigned LOCK_CYCLES  = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_chan,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic                  sync_req,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] tick,
    output logic                  locked
);

    localparam int unsigned          LockW   = $clog2(LOCK_CYCLES + 1);
    localparam logic [LockW-1:0]     LockMax = LockW'(LOCK_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] DivOne  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DivTwo  = DIV_WIDTH'(2);

    function automatic logic [DIV_WIDTH-1:0] reset_div(int ch);
        int unsigned d;
        d = (ch == 1) ? DIV_DEFAULT1 : DIV_DEFAULT0;
        if (d < 2) d = 2;
        return DIV_WIDTH'(d);
    endfunction

    logic [DIV_WIDTH-1:0]  cnt_q [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]  cnt_d [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]  div_q [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0]  div_d [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
    logic [NUM_CLOCKS-1:0] tick_q, tick_d;
    logic [NUM_CLOCKS-1:0] wrap, hit;
    logic                  pending_q, pending_d;
    logic [2:0]            pending_chan_q, pending_chan_d;
    logic [DIV_WIDTH-1:0]  pending_div_q, pending_div_d;
    logic [LockW-1:0]      lock_cnt_q, lock_cnt_d;
    logic                  locked_q, locked_d;
    logic                  cfg_take, apply, lock_clear;
    logic [DIV_WIDTH-1:0]  div_clamped;

    assign cfg_ready   = ~pending_q;
    // Writes to channels that do not exist are accepted and dropped.
    assign cfg_take    = cfg_valid & ~pending_q & ({1'b0, cfg_chan} < 4'(NUM_CLOCKS));
    assign div_clamped = (cfg_div < DivTwo) ? DivTwo : cfg_div;

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        outclk_d = '0;
        tick_d   = '0;
        wrap     = '0;
        hit      = '0;
        apply    = 1'b0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            wrap[i]     = (cnt_q[i] == div_q[i] - DivOne);
            hit[i]      = pending_q && (pending_chan_q == 3'(i));
            cnt_d[i]    = (wrap[i] || sync_req) ? '0 : cnt_q[i] + DivOne;
            outclk_d[i] = (cnt_q[i] < (div_q[i] >> 1));
            tick_d[i]   = (cnt_q[i] == '0);
            // Swap only at a period boundary or a sync point so no runt pulse appears.
            if (hit[i] && (wrap[i] || sync_req)) begin
                div_d[i] = pending_div_q;
                apply    = 1'b1;
            end
        end
    end

    always_comb begin
        pending_d      = pending_q;
        pending_chan_d = pending_chan_q;
        pending_div_d  = pending_div_q;
        if (apply) pending_d = 1'b0;
        if (cfg_take) begin
            pending_d      = 1'b1;
            pending_chan_d = cfg_chan;
            pending_div_d  = div_clamped;
        end

        lock_clear = sync_req | cfg_take | pending_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (lock_clear) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (lock_cnt_q == LockMax) begin
            locked_d = 1'b1;
        end else begin
            lock_cnt_d = lock_cnt_q + LockW'(1);
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= reset_div(i);
            end
            outclk_q       <= '0;
            tick_q         <= '0;
            pending_q      <= 1'b0;
            pending_chan_q <= '0;
            pending_div_q  <= '0;
            lock_cnt_q     <= '0;
            locked_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            outclk_q       <= outclk_d;
            tick_q         <= tick_d;
            pending_q      <= pending_d;
            pending_chan_q <= pending_chan_d;
            pending_div_q  <= pending_div_d;
            lock_cnt_q     <= lock_cnt_d;
            locked_q       <= locked_d;
        end
    end

    assign outclk = outclk_q;
    assign tick   = tick_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_clkgen_multi_div.sv
// Directed bench for clkgen_multi_div: defaults, mid-period writes, back-to-back writes,
// divisor clamp, invalid channel, sync alignment and reset during a pending write.
module tb_clkgen_multi_div;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_chan = 3'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       sync_req = 1'b0;
    logic [1:0] outclk;
    logic [1:0] tick;
    logic       locked;

    int total = 0;
    int bad   = 0;

    clkgen_multi_div #(
        .NUM_CLOCKS  (2),
        .DIV_WIDTH   (8),
        .DIV_DEFAULT0(10),
        .DIV_DEFAULT1(25),
        .LOCK_CYCLES (16)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_div  (cfg_div),
        .sync_req (sync_req),
        .outclk   (outclk),
        .tick     (tick),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Leaves rst released so the next posedge is edge 1 after release.
    task automatic apply_reset();
        rst = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan = 3'd0;
        cfg_div = 8'd0;
        sync_req = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0] eo, et;
        logic       el;
        rst = 1'b0;
        repeat (2) step();
        total++; if (outclk !== 2'b00) begin bad++; $display("FAIL rst_outclk got=%b exp=00", outclk); end
        total++; if (tick !== 2'b00) begin bad++; $display("FAIL rst_tick got=%b exp=00", tick); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cfg_ready); end
        rst = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            step();
            eo = {(((n - 1) % 25) < 12), (((n - 1) % 10) < 5)};
            et = {(((n - 1) % 25) == 0), (((n - 1) % 10) == 0)};
            el = (n >= 16);
            total++; if (outclk !== eo) begin bad++; $display("FAIL dflt_outclk n=%0d got=%b exp=%b", n, outclk, eo); end
            total++; if (tick !== et) begin bad++; $display("FAIL dflt_tick n=%0d got=%b exp=%b", n, tick, et); end
            total++; if (locked !== el) begin bad++; $display("FAIL dflt_locked n=%0d got=%b exp=%b", n, locked, el); end
        end
    endtask

    task automatic test_write_mid();
        logic e0, e1, et, el;
        apply_reset();
        repeat (3) step();
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 8'd4;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_pre got=%b exp=1", cfg_ready); end
        for (int n = 4; n <= 10; n++) begin
            step();
            cfg_valid = 1'b0;
            e0 = (((n - 1) % 10) < 5);
            total++; if (outclk[0] !== e0) begin bad++; $display("FAIL wr_old_period n=%0d got=%b exp=%b", n, outclk[0], e0); end
            total++; if (cfg_ready !== (n == 10)) begin bad++; $display("FAIL wr_ready n=%0d got=%b exp=%b", n, cfg_ready, (n == 10)); end
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL wr_lock_drop n=%0d got=%b exp=0", n, locked); end
        end
        for (int j = 1; j <= 20; j++) begin
            step();
            e0 = (((j - 1) % 4) < 2);
            et = (((j - 1) % 4) == 0);
            e1 = (((j + 9) % 25) < 12);
            el = (j >= 16);
            total++; if (outclk[0] !== e0) begin bad++; $display("FAIL wr_new_period j=%0d got=%b exp=%b", j, outclk[0], e0); end
            total++; if (tick[0] !== et) begin bad++; $display("FAIL wr_new_tick j=%0d got=%b exp=%b", j, tick[0], et); end
            total++; if (outclk[1] !== e1) begin bad++; $display("FAIL wr_ch1_intact j=%0d got=%b exp=%b", j, outclk[1], e1); end
            total++; if (locked !== el) begin bad++; $display("FAIL wr_relock j=%0d got=%b exp=%b", j, locked, el); end
        end
    endtask

    task automatic test_back_to_back();
        logic e1, et;
        apply_reset();
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_div = 8'd6;
        for (int n = 1; n <= 25; n++) begin
            step();
            cfg_div = 8'd8;
            total++; if (cfg_ready !== (n == 25)) begin bad++; $display("FAIL b2b_hold n=%0d got=%b exp=%b", n, cfg_ready, (n == 25)); end
        end
        for (int n = 26; n <= 31; n++) begin
            step();
            cfg_valid = 1'b0;
            e1 = (((n - 26) % 6) < 3);
            et = (((n - 26) % 6) == 0);
            total++; if (outclk[1] !== e1) begin bad++; $display("FAIL b2b_div6 n=%0d got=%b exp=%b", n, outclk[1], e1); end
            total++; if (tick[1] !== et) begin bad++; $display("FAIL b2b_tick6 n=%0d got=%b exp=%b", n, tick[1], et); end
            total++; if (cfg_ready !== (n == 31)) begin bad++; $display("FAIL b2b_ready2 n=%0d got=%b exp=%b", n, cfg_ready, (n == 31)); end
        end
        for (int n = 32; n <= 48; n++) begin
            step();
            e1 = (((n - 32) % 8) < 4);
            et = (((n - 32) % 8) == 0);
            total++; if (outclk[1] !== e1) begin bad++; $display("FAIL b2b_div8 n=%0d got=%b exp=%b", n, outclk[1], e1); end
            total++; if (tick[1] !== et) begin bad++; $display("FAIL b2b_tick8 n=%0d got=%b exp=%b", n, tick[1], et); end
        end
    endtask

    task automatic test_clamp_and_bad_chan();
        logic e0;
        apply_reset();
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 8'd0;
        for (int n = 1; n <= 18; n++) begin
            step();
            cfg_valid = 1'b0;
            total++; if (cfg_ready !== (n >= 10)) begin bad++; $display("FAIL clamp0_ready n=%0d got=%b exp=%b", n, cfg_ready, (n >= 10)); end
            if (n >= 11) begin
                e0 = ((n % 2) == 1);
                total++; if (outclk[0] !== e0) begin bad++; $display("FAIL clamp0_period n=%0d got=%b exp=%b", n, outclk[0], e0); end
            end
        end
        cfg_valid = 1'b1; cfg_div = 8'd1;
        for (int n = 19; n <= 40; n++) begin
            step();
            cfg_valid = 1'b0;
            e0 = ((n % 2) == 1);
            total++; if (outclk[0] !== e0) begin bad++; $display("FAIL clamp1_period n=%0d got=%b exp=%b", n, outclk[0], e0); end
            total++; if (cfg_ready !== (n >= 20)) begin bad++; $display("FAIL clamp1_ready n=%0d got=%b exp=%b", n, cfg_ready, (n >= 20)); end
            total++; if (locked !== (n >= 36)) begin bad++; $display("FAIL clamp1_locked n=%0d got=%b exp=%b", n, locked, (n >= 36)); end
        end
        cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_div = 8'd3;
        for (int n = 41; n <= 50; n++) begin
            step();
            cfg_valid = 1'b0;
            e0 = ((n % 2) == 1);
            total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL badch_ready n=%0d got=%b exp=1", n, cfg_ready); end
            total++; if (locked !== 1'b1) begin bad++; $display("FAIL badch_locked n=%0d got=%b exp=1", n, locked); end
            total++; if (outclk[0] !== e0) begin bad++; $display("FAIL badch_period n=%0d got=%b exp=%b", n, outclk[0], e0); end
        end
    endtask

    task automatic test_sync();
        logic [1:0] eo, et;
        logic       e0;
        int         j;
        apply_reset();
        repeat (33) step();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL sync_prelock got=%b exp=1", locked); end
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        total++; if (tick !== 2'b00) begin bad++; $display("FAIL sync_edge_tick got=%b exp=00", tick); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL sync_edge_locked got=%b exp=0", locked); end
        for (int n = 35; n <= 65; n++) begin
            step();
            j = n - 35;
            eo = {((j % 25) < 12), ((j % 10) < 5)};
            et = {((j % 25) == 0), ((j % 10) == 0)};
            total++; if (outclk !== eo) begin bad++; $display("FAIL sync_outclk n=%0d got=%b exp=%b", n, outclk, eo); end
            total++; if (tick !== et) begin bad++; $display("FAIL sync_tick n=%0d got=%b exp=%b", n, tick, et); end
            total++; if (locked !== (n >= 50)) begin bad++; $display("FAIL sync_locked n=%0d got=%b exp=%b", n, locked, (n >= 50)); end
        end
        // Pending write for ch1 is applied at the next sync instead of the period end.
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_div = 8'd5;
        for (int n = 66; n <= 68; n++) begin
            step();
            cfg_valid = 1'b0;
            total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL syncpend_hold n=%0d got=%b exp=0", n, cfg_ready); end
        end
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL syncpend_ready got=%b exp=1", cfg_ready); end
        for (int n = 70; n <= 84; n++) begin
            step();
            j = n - 70;
            eo = {((j % 5) < 2), ((j % 10) < 5)};
            et = {((j % 5) == 0), ((j % 10) == 0)};
            total++; if (outclk !== eo) begin bad++; $display("FAIL syncpend_outclk n=%0d got=%b exp=%b", n, outclk, eo); end
            total++; if (tick !== et) begin bad++; $display("FAIL syncpend_tick n=%0d got=%b exp=%b", n, tick, et); end
        end
        // Write accepted on the sync edge itself waits for the next natural period end.
        sync_req = 1'b1; cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 8'd4;
        step();
        sync_req = 1'b0; cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL synccfg_pending got=%b exp=0", cfg_ready); end
        for (int k = 1; k <= 16; k++) begin
            step();
            e0 = (k <= 10) ? ((k - 1) < 5) : (((k - 11) % 4) < 2);
            total++; if (outclk[0] !== e0) begin bad++; $display("FAIL synccfg_outclk k=%0d got=%b exp=%b", k, outclk[0], e0); end
            total++; if (cfg_ready !== (k >= 10)) begin bad++; $display("FAIL synccfg_ready k=%0d got=%b exp=%b", k, cfg_ready, (k >= 10)); end
        end
    endtask

    task automatic test_reset_mid();
        logic e0;
        apply_reset();
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 8'd4;
        for (int n = 1; n <= 5; n++) begin
            step();
            cfg_valid = 1'b0;
        end
        total++; if (outclk[0] !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b exp=1", outclk[0]); end
        rst = 1'b0;
        #1;
        total++; if (outclk !== 2'b00) begin bad++; $display("FAIL rmid_outclk got=%b exp=00", outclk); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rmid_locked got=%b exp=0", locked); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", cfg_ready); end
        step();
        rst = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step();
            e0 = (((n - 1) % 10) < 5);
            total++; if (outclk[0] !== e0) begin bad++; $display("FAIL rmid_dflt n=%0d got=%b exp=%b", n, outclk[0], e0); end
            total++; if (locked !== (n >= 16)) begin bad++; $display("FAIL rmid_lock n=%0d got=%b exp=%b", n, locked, (n >= 16)); end
        end
    endtask

    initial begin
        test_reset();
        test_write_mid();
        test_back_to_back();
        test_clamp_and_bad_chan();
        test_sync();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
